i2s_stereo_tx: RTL and testbench

Parametrised I2S transmitter for core audio output. It replaces ad-hoc inline mono shifters with a stereo, width-generic serializer. It has a small sample FIFO, a valid/ready handshake, a mono mode and defined underflow handling. The block sits in the audio clock domain: the core's cdc_buffer output or a resampler feeds it, and it drives audio_if dac/lrck.

---
 rtl/audio_pkg.sv | 17 +
 rtl/i2s_frame_fifo.sv | 60 ++++++
 rtl/i2s_stereo_tx.sv | 143 ++++++++++++++
 tb/tb_i2s_stereo_tx.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions: default I2S slot size and the serializer load-word builder.
package audio_pkg;

    localparam int I2S_SLOT_BITS_DEFAULT = 32;
    localparam int MAX_SLOT_BITS         = 64;

    // Left-justified slot word: one I2S delay bit, the sample MSB first, then zero padding.
    function automatic logic [MAX_SLOT_BITS-1:0] slot_word(
        input logic [MAX_SLOT_BITS-1:0] sample,
        input int unsigned              sample_width
    );
        logic [MAX_SLOT_BITS-1:0] mask;
        mask = (64'd1 << sample_width) - 64'd1;
        return (sample & mask) << (MAX_SLOT_BITS - 1 - sample_width);
    endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous frame FIFO with occupancy level; pushes when full and pops when empty are dropped.
module i2s_frame_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LEVEL_FULL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            // NOTE: storage is cleared on reset because a repeated-frame underflow may replay it; this forces flops, not RAM.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                level <= level + LEVEL_ONE;
            end else if (do_pop && !do_push) begin
                level <= level - LEVEL_ONE;
            end
        end
    end

endmodule

// File: rtl/i2s_stereo_tx.sv
// Stereo I2S serializer: frame FIFO, bit-clock divider, slot sequencing, mono and underflow handling.
module i2s_stereo_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH   = 16,
    parameter int SLOT_BITS      = I2S_SLOT_BITS_DEFAULT,
    parameter int SCLK_DIV       = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int UNDERFLOW_ZERO = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_valid,
    output logic                           sample_ready,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_left,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_right,
    input  logic                           mono,
    output logic                           i2s_sclk,
    output logic                           i2s_lrck,
    output logic                           i2s_dac,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           underflow
);

    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int BIT_W = $clog2(SLOT_BITS);
    localparam int PAD_W = MAX_SLOT_BITS - SAMPLE_WIDTH;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    typedef struct packed {
        logic signed [SAMPLE_WIDTH-1:0] left;
        logic signed [SAMPLE_WIDTH-1:0] right;
    } frame_t;

    logic [DIV_W-1:0]               div_cnt;
    logic [DIV_W-1:0]               div_next;
    logic [BIT_W-1:0]               bit_cnt;
    logic                           started;
    logic                           shift_evt;
    logic                           slot_load;
    logic                           left_start;
    logic                           right_start;
    logic [MAX_SLOT_BITS-1:0]       shifter;
    logic [MAX_SLOT_BITS-1:0]       slot_ext;
    logic signed [SAMPLE_WIDTH-1:0] slot_sample;
    frame_t                         hold_q;
    frame_t                         hold_d;
    frame_t                         fifo_out;
    logic [2*SAMPLE_WIDTH-1:0]      fifo_rdata;
    logic                           mono_q;
    logic                           mono_d;
    logic                           fifo_pop;
    logic                           fifo_empty;
    logic                           fifo_full;
    logic                           underflow_d;

    i2s_frame_fifo #(
        .WIDTH (2 * SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (sample_valid && sample_ready),
        .pop   (fifo_pop),
        .wdata ({sample_left, sample_right}),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fifo_out     = fifo_rdata;
    assign sample_ready = !fifo_full;
    assign i2s_dac      = shifter[MAX_SLOT_BITS-1];

    // The very first shift event after reset is forced to be a (left) slot load.
    assign shift_evt   = (div_cnt == DIV_LAST);
    assign div_next    = shift_evt ? '0 : div_cnt + DIV_ONE;
    assign slot_load   = shift_evt && (!started || bit_cnt == BIT_LAST);
    assign left_start  = slot_load && i2s_lrck;
    assign right_start = slot_load && !i2s_lrck;

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
        hold_d      = hold_q;
        mono_d      = mono_q;
        fifo_pop    = 1'b0;
        underflow_d = 1'b0;
        slot_sample = hold_q.right;
        if (left_start) begin
            mono_d = mono;
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                hold_d   = fifo_out;
            end else begin
                underflow_d = 1'b1;
                if (UNDERFLOW_ZERO != 0) begin
                    hold_d = '0;
                end
            end
            slot_sample = hold_d.left;
        end else if (right_start) begin
            slot_sample = mono_q ? hold_q.left : hold_q.right;
        end
        slot_ext = {{PAD_W{1'b0}}, slot_sample};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            started   <= 1'b0;
            i2s_sclk  <= 1'b0;
            i2s_lrck  <= 1'b1;
            shifter   <= '0;
            hold_q    <= '0;
            mono_q    <= 1'b0;
            underflow <= 1'b0;
        end else begin
            div_cnt   <= div_next;
            i2s_sclk  <= (div_next >= DIV_HALF);
            underflow <= underflow_d;
            hold_q    <= hold_d;
            mono_q    <= mono_d;
            if (shift_evt) begin
                started <= 1'b1;
                if (slot_load) begin
                    bit_cnt  <= '0;
                    i2s_lrck <= ~i2s_lrck;
                    shifter  <= slot_word(slot_ext, SAMPLE_WIDTH);
                end else begin
                    bit_cnt <= bit_cnt + BIT_ONE;
                    shifter <= shifter << 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_stereo_tx.sv
// Self-checking bench for i2s_stereo_tx: three configurations checked against a bit-level I2S frame model.
module tb_i2s_stereo_tx;

    localparam int NDUT = 3;  // 0: defaults, 1: UNDERFLOW_ZERO=1, 2: 24-bit samples with SCLK_DIV=2

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic        rst_s   [NDUT];
    logic        valid_s [NDUT];
    logic        ready_s [NDUT];
    logic [23:0] left_s  [NDUT];
    logic [23:0] right_s [NDUT];
    logic        mono_s  [NDUT];
    logic        sclk_s  [NDUT];
    logic        lrck_s  [NDUT];
    logic        dac_s   [NDUT];
    logic        uf_s    [NDUT];
    logic [2:0]  level_s [NDUT];

    i2s_stereo_tx #(.SAMPLE_WIDTH(16), .SCLK_DIV(4), .UNDERFLOW_ZERO(0)) dut_rep (
        .clk(clk), .reset(rst_s[0]), .sample_valid(valid_s[0]), .sample_ready(ready_s[0]),
        .sample_left(left_s[0][15:0]), .sample_right(right_s[0][15:0]), .mono(mono_s[0]),
        .i2s_sclk(sclk_s[0]), .i2s_lrck(lrck_s[0]), .i2s_dac(dac_s[0]),
        .fifo_level(level_s[0]), .underflow(uf_s[0]));

    i2s_stereo_tx #(.SAMPLE_WIDTH(16), .SCLK_DIV(4), .UNDERFLOW_ZERO(1)) dut_zero (
        .clk(clk), .reset(rst_s[1]), .sample_valid(valid_s[1]), .sample_ready(ready_s[1]),
        .sample_left(left_s[1][15:0]), .sample_right(right_s[1][15:0]), .mono(mono_s[1]),
        .i2s_sclk(sclk_s[1]), .i2s_lrck(lrck_s[1]), .i2s_dac(dac_s[1]),
        .fifo_level(level_s[1]), .underflow(uf_s[1]));

    i2s_stereo_tx #(.SAMPLE_WIDTH(24), .SCLK_DIV(2), .UNDERFLOW_ZERO(0)) dut_wide (
        .clk(clk), .reset(rst_s[2]), .sample_valid(valid_s[2]), .sample_ready(ready_s[2]),
        .sample_left(left_s[2]), .sample_right(right_s[2]), .mono(mono_s[2]),
        .i2s_sclk(sclk_s[2]), .i2s_lrck(lrck_s[2]), .i2s_dac(dac_s[2]),
        .fifo_level(level_s[2]), .underflow(uf_s[2]));

    // Reference: each 32-bit slot is one delay bit, the sample MSB first, then zeros.
    function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r, input int sw);
        logic [63:0] v;
        logic [23:0] s;
        logic        b;
        v = '0;
        for (int slot = 0; slot < 2; slot++) begin
            s = (slot == 0) ? l : r;
            for (int i = 0; i < 32; i++) begin
                b = (i >= 1 && i <= sw) ? s[sw-i] : 1'b0;
                v = {v[62:0], b};
            end
        end
        return v;
    endfunction

    function automatic logic [23:0] rnd(input int sw);
        return 24'($urandom_range(0, (1 << sw) - 1));
    endfunction

    task automatic do_reset(input int d);
        @(negedge clk);
        rst_s[d]   = 1'b1;
        valid_s[d] = 1'b0;
        mono_s[d]  = 1'b0;
        repeat (3) @(negedge clk);
        rst_s[d] = 1'b0;
    endtask

    task automatic push_frame(input int d, input logic [23:0] l, input logic [23:0] r);
        bit done = 0;
        valid_s[d] = 1'b1;
        left_s[d]  = l;
        right_s[d] = r;
        for (int c = 0; c < 2000 && !done; c++) begin
            if (ready_s[d] === 1'b1) done = 1;
            @(negedge clk);
        end
        valid_s[d] = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL push_timeout dut%0d: ready never seen", d);
        end
    endtask

    task automatic wait_left_start(input int d, output int start_cyc, output logic uf, output logic [2:0] lvl);
        logic prev;
        bit   found = 0;
        start_cyc = -1;
        uf        = 1'bx;
        lvl       = 'x;
        prev      = lrck_s[d];
        for (int c = 0; c < 700 && !found; c++) begin
            @(negedge clk);
            if (prev === 1'b1 && lrck_s[d] === 1'b0) begin
                found     = 1;
                start_cyc = cyc;
                uf        = uf_s[d];
                lvl       = level_s[d];
            end
            prev = lrck_s[d];
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL left_start_timeout dut%0d: no lrck 1->0 edge", d);
        end
    endtask

    task automatic collect_bits(input int d, output logic [63:0] bits);
        logic prev;
        int   n = 0;
        bits = '0;
        prev = sclk_s[d];
        for (int c = 0; c < 700 && n < 64; c++) begin
            @(negedge clk);
            if (prev === 1'b0 && sclk_s[d] === 1'b1) begin
                bits = {bits[62:0], dac_s[d]};
                n++;
            end
            prev = sclk_s[d];
        end
        n_tests++;
        if (n != 64) begin
            n_fail++;
            $display("FAIL sclk_timeout dut%0d: got %0d rising edges, expected 64", d, n);
        end
    endtask

    task automatic collect_frame(input int d, output logic [63:0] bits, output int st,
                                 output logic uf, output logic [2:0] lvl);
        wait_left_start(d, st, uf, lvl);
        collect_bits(d, bits);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_tests++; if (dac_s[0] !== 1'b0)   begin n_fail++; $display("FAIL reset_dac: got %b expected 0", dac_s[0]); end
        n_tests++; if (lrck_s[0] !== 1'b1)  begin n_fail++; $display("FAIL reset_lrck: got %b expected 1", lrck_s[0]); end
        n_tests++; if (sclk_s[0] !== 1'b0)  begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", sclk_s[0]); end
        n_tests++; if (ready_s[0] !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready_s[0]); end
        n_tests++; if (level_s[0] !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level_s[0]); end
        n_tests++; if (uf_s[0] !== 1'b0)    begin n_fail++; $display("FAIL reset_underflow: got %b expected 0", uf_s[0]); end
    endtask

    task automatic test_stream;
        logic [23:0] ql[$], qr[$];
        logic [23:0] last_l, last_r, el, er, l, r;
        logic [63:0] bits;
        logic        uf, euf;
        logic [2:0]  lvl;
        int          st, prev_st;
        last_l = '0; last_r = '0; prev_st = 0;
        do_reset(0);
        fork
            begin
                push_frame(0, 24'h8001, 24'h1234);
                ql.push_back(24'h8001); qr.push_back(24'h1234);
                for (int i = 0; i < 4; i++) begin
                    l = rnd(16); r = rnd(16);
                    push_frame(0, l, r);
                    ql.push_back(l); qr.push_back(r);
                end
            end
            begin
                for (int f = 0; f < 7; f++) begin
                    collect_frame(0, bits, st, uf, lvl);
                    if (ql.size() > 0) begin
                        el = ql.pop_front(); er = qr.pop_front(); euf = 1'b0;
                        last_l = el; last_r = er;
                    end else begin
                        el = last_l; er = last_r; euf = 1'b1;
                    end
                    n_tests++;
                    if (bits !== exp_frame(el, er, 16)) begin
                        n_fail++;
                        $display("FAIL stream_bits frame%0d: got %h expected %h", f, bits, exp_frame(el, er, 16));
                    end
                    n_tests++;
                    if (uf !== euf) begin n_fail++; $display("FAIL stream_underflow frame%0d: got %b expected %b", f, uf, euf); end
                    if (f > 0) begin
                        n_tests++;
                        if (st - prev_st !== 256) begin n_fail++; $display("FAIL stream_period frame%0d: got %0d expected 256", f, st - prev_st); end
                    end
                    prev_st = st;
                end
            end
        join
    endtask

    task automatic test_mono;
        logic [23:0] ml[3], mr[3];
        logic [63:0] bits;
        logic        uf;
        logic [2:0]  lvl;
        int          st;
        ml[0] = 24'h7FFF; mr[0] = 24'h0000;
        for (int i = 1; i < 3; i++) begin ml[i] = rnd(16); mr[i] = rnd(16); end
        do_reset(0);
        mono_s[0] = 1'b1;
        fork
            for (int i = 0; i < 3; i++) push_frame(0, ml[i], mr[i]);
            for (int f = 0; f < 3; f++) begin
                collect_frame(0, bits, st, uf, lvl);
                n_tests++;
                if (bits !== exp_frame(ml[f], ml[f], 16)) begin
                    n_fail++; $display("FAIL mono_bits frame%0d: got %h expected %h", f, bits, exp_frame(ml[f], ml[f], 16));
                end
                n_tests++;
                if (lvl !== 3'(2 - f)) begin n_fail++; $display("FAIL mono_level frame%0d: got %0d expected %0d", f, lvl, 2 - f); end
            end
        join
        mono_s[0] = 1'b0;
        collect_frame(0, bits, st, uf, lvl);
        n_tests++;
        if (bits !== exp_frame(ml[2], mr[2], 16)) begin
            n_fail++; $display("FAIL mono_off_bits: got %h expected %h", bits, exp_frame(ml[2], mr[2], 16));
        end
        n_tests++;
        if (uf !== 1'b1) begin n_fail++; $display("FAIL mono_off_underflow: got %b expected 1", uf); end
    endtask

    task automatic test_full;
        logic prev;
        int   falls = 0, acc = 0, since = 0;
        do_reset(0);
        valid_s[0] = 1'b1;
        left_s[0]  = rnd(16);
        right_s[0] = rnd(16);
        prev = lrck_s[0];
        for (int c = 0; c < 1400; c++) begin
            @(negedge clk);
            since++;
            if (prev === 1'b1 && lrck_s[0] === 1'b0) begin
                falls++;
                if (falls >= 2) begin
                    n_tests++;
                    if (acc !== 1) begin n_fail++; $display("FAIL full_accepts window%0d: got %0d expected 1", falls - 1, acc); end
                end
                acc   = 0;
                since = 0;
            end
            if (falls >= 1 && since == 10) begin
                n_tests++;
                if (level_s[0] !== 3'd4 || ready_s[0] !== 1'b0) begin
                    n_fail++; $display("FAIL full_level: got level %0d ready %b expected level 4 ready 0", level_s[0], ready_s[0]);
                end
            end
            if (valid_s[0] === 1'b1 && ready_s[0] === 1'b1) acc++;
            prev = lrck_s[0];
        end
        valid_s[0] = 1'b0;
        n_tests++;
        if (falls !== 6) begin n_fail++; $display("FAIL full_frames: got %0d left starts expected 6", falls); end
    endtask

    task automatic test_reset_mid;
        logic [23:0] nl, nr;
        logic [63:0] bits;
        logic        uf;
        logic [2:0]  lvl;
        int          st, rel;
        bit          seen = 0;
        do_reset(0);
        push_frame(0, rnd(16), rnd(16));
        wait_left_start(0, st, uf, lvl);
        for (int i = 0; i < 3; i++) push_frame(0, rnd(16), rnd(16));
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (lrck_s[0] === 1'b1) seen = 1;
        end
        repeat (20) @(negedge clk);
        n_tests++;
        if (!seen || level_s[0] !== 3'd3) begin
            n_fail++; $display("FAIL midreset_pre: right slot %0d level %0d expected right slot 1 level 3", seen, level_s[0]);
        end
        #2 rst_s[0] = 1'b1;
        #1;
        n_tests++;
        if ({dac_s[0], lrck_s[0], sclk_s[0], ready_s[0], uf_s[0]} !== 5'b01010) begin
            n_fail++; $display("FAIL midreset_outputs: got dac/lrck/sclk/ready/uf %b expected 01010",
                               {dac_s[0], lrck_s[0], sclk_s[0], ready_s[0], uf_s[0]});
        end
        n_tests++;
        if (level_s[0] !== 3'd0) begin n_fail++; $display("FAIL midreset_level: got %0d expected 0", level_s[0]); end
        @(negedge clk);
        rst_s[0] = 1'b0;
        rel = cyc;
        nl = rnd(16); nr = rnd(16);
        push_frame(0, nl, nr);
        collect_frame(0, bits, st, uf, lvl);
        n_tests++;
        if (st - rel !== 4) begin n_fail++; $display("FAIL midreset_first_load: got %0d cycles expected 4", st - rel); end
        n_tests++;
        if (bits !== exp_frame(nl, nr, 16) || uf !== 1'b0) begin
            n_fail++; $display("FAIL midreset_bits: got %h uf %b expected %h uf 0", bits, uf, exp_frame(nl, nr, 16));
        end
    endtask

    task automatic test_underflow_zero;
        logic [23:0] l, r;
        logic [63:0] bits;
        logic        uf;
        logic [2:0]  lvl;
        int          st;
        l = rnd(16); r = rnd(16);
        do_reset(1);
        push_frame(1, l, r);
        collect_frame(1, bits, st, uf, lvl);
        n_tests++;
        if (bits !== exp_frame(l, r, 16) || uf !== 1'b0) begin
            n_fail++; $display("FAIL zero_first: got %h uf %b expected %h uf 0", bits, uf, exp_frame(l, r, 16));
        end
        for (int f = 1; f < 3; f++) begin
            collect_frame(1, bits, st, uf, lvl);
            n_tests++;
            if (bits !== 64'd0) begin n_fail++; $display("FAIL zero_bits frame%0d: got %h expected 0", f, bits); end
            n_tests++;
            if (uf !== 1'b1) begin n_fail++; $display("FAIL zero_underflow frame%0d: got %b expected 1", f, uf); end
        end
    endtask

    task automatic test_wide;
        logic [23:0] l, r;
        logic [63:0] bits;
        logic        uf;
        logic [2:0]  lvl;
        int          st, st0;
        l = rnd(24); r = rnd(24);
        do_reset(2);
        push_frame(2, l, r);
        collect_frame(2, bits, st0, uf, lvl);
        n_tests++;
        if (bits !== exp_frame(l, r, 24) || uf !== 1'b0) begin
            n_fail++; $display("FAIL wide_bits: got %h uf %b expected %h uf 0", bits, uf, exp_frame(l, r, 24));
        end
        collect_frame(2, bits, st, uf, lvl);
        n_tests++;
        if (bits !== exp_frame(l, r, 24) || uf !== 1'b1) begin
            n_fail++; $display("FAIL wide_repeat: got %h uf %b expected %h uf 1", bits, uf, exp_frame(l, r, 24));
        end
        n_tests++;
        if (st - st0 !== 128) begin n_fail++; $display("FAIL wide_period: got %0d expected 128", st - st0); end
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst_s[d]   = 1'b1;
            valid_s[d] = 1'b0;
            left_s[d]  = '0;
            right_s[d] = '0;
            mono_s[d]  = 1'b0;
        end
        repeat (2) @(negedge clk);
        test_reset;
        test_stream;
        test_mono;
        test_full;
        test_reset_mid;
        test_underflow_zero;
        test_wide;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
